quad_decoder_param: RTL and testbench



---
 rtl/quad_decoder_param.sv | 201 ++++++++++++++++++++
 tb/tb_quad_decoder_param.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_param.sv
// Quadrature encoder decoder: per-channel sync + debounce, x4/x1 position count,
// illegal-transition flag. Optional windowed velocity when QDEC_VELOCITY_EN is defined.

module qdec_filter #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic f
);
    logic s1, s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign f = s2;
        end else begin : g_debounce
            localparam int RW = $clog2(DEBOUNCE + 1);
            logic [RW-1:0] run;
            logic          fq;

            // Any sample agreeing with the held value restarts the run.
            always_ff @(posedge clk) begin
                if (reset) begin
                    run <= '0;
                    fq  <= 1'b0;
                end else if (s2 == fq) begin
                    run <= '0;
                end else if (run == RW'(DEBOUNCE - 1)) begin
                    fq  <= s2;
                    run <= '0;
                end else begin
                    run <= run + 1'b1;
                end
            end

            assign f = fq;
        end
    endgenerate
endmodule

module quad_decoder_param #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4,
    parameter int MODE     = 0,
    parameter int SATURATE = 0,
    parameter int WINDOW   = 1000,
    parameter int VWIDTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              A,
    input  logic              B,
    input  logic              clear,
    output logic [WIDTH-1:0]  count,
    output logic              CW,
    output logic              CWW,
    output logic              step,
    output logic              err,
    output logic [VWIDTH-1:0] velocity,
    output logic              vel_valid
);
    logic [1:0] raw, f, pf, chg, pos_f, pos_p;
    logic       legal, illegal, fwd, rev;
    logic       up, dn, inc, dec, at_max, at_min;

    generate
        if (WINDOW < 2) begin : g_window_chk
            $error("quad_decoder_param: WINDOW must be >= 2");
        end
    endgenerate

    assign raw = {A, B};

    generate
        for (genvar ch = 0; ch < 2; ch++) begin : g_ch
            qdec_filter #(.DEBOUNCE(DEBOUNCE)) u_flt (
                .clk   (clk),
                .reset (reset),
                .din   (raw[ch]),
                .f     (f[ch])
            );
        end
    endgenerate

    // Map {A,B} onto a 0..3 ring so clockwise is always +1 mod 4.
    assign pos_f   = {f[0],  f[1]  ^ f[0]};
    assign pos_p   = {pf[0], pf[1] ^ pf[0]};
    assign chg     = f ^ pf;
    assign legal   = (chg == 2'b01) || (chg == 2'b10);
    assign illegal = (chg == 2'b11);
    assign fwd     = legal && (pos_f == 2'(pos_p + 2'd1));
    assign rev     = legal && !fwd;

    generate
        if (MODE == 1) begin : g_x1
            assign up = fwd && (pf == 2'b01) && (f == 2'b00);
            assign dn = rev && (pf == 2'b00) && (f == 2'b01);
        end else begin : g_x4
            assign up = fwd;
            assign dn = rev;
        end
    endgenerate

    assign at_max = (count == {WIDTH{1'b1}});
    assign at_min = (count == '0);

    generate
        if (SATURATE != 0) begin : g_sat
            assign inc = up && !clear && !at_max;
            assign dec = dn && !clear && !at_min;
        end else begin : g_wrap
            assign inc = up && !clear;
            assign dec = dn && !clear;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pf    <= 2'b00;
            count <= '0;
            CW    <= 1'b0;
            CWW   <= 1'b0;
            step  <= 1'b0;
            err   <= 1'b0;
        end else begin
            pf   <= f;
            step <= inc || dec;
            if (clear) begin
                count <= '0;
                err   <= 1'b0;
            end else begin
                if (illegal)
                    err <= 1'b1;
                if (legal) begin
                    CW  <= fwd;
                    CWW <= rev;
                end
                if (inc)
                    count <= count + 1'b1;
                else if (dec)
                    count <= count - 1'b1;
            end
        end
    end

`ifdef QDEC_VELOCITY_EN
    localparam int              WW   = $clog2(WINDOW);
    localparam logic [VWIDTH-1:0] VMAX = {1'b0, {(VWIDTH-1){1'b1}}};
    localparam logic [VWIDTH-1:0] VMIN = {1'b1, {(VWIDTH-1){1'b0}}};

    logic [WW-1:0]     wcnt;
    logic [VWIDTH-1:0] acc, acc_nx;

    // Two's-complement accumulator clamped at the signed limits.
    always_comb begin
        acc_nx = acc;
        if (inc && (acc != VMAX))
            acc_nx = acc + VWIDTH'(1);
        else if (dec && (acc != VMIN))
            acc_nx = acc - VWIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt      <= '0;
            acc       <= '0;
            velocity  <= '0;
            vel_valid <= 1'b0;
        end else begin
            vel_valid <= 1'b0;
            if (clear) begin
                wcnt <= '0;
                acc  <= '0;
            end else if (wcnt == WW'(WINDOW - 1)) begin
                velocity  <= acc_nx;
                vel_valid <= 1'b1;
                acc       <= '0;
                wcnt      <= '0;
            end else begin
                wcnt <= wcnt + 1'b1;
                acc  <= acc_nx;
            end
        end
    end
`else
    assign velocity  = '0;
    assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quad_decoder_param.sv
// Directed bench for quad_decoder_param: four instances (x4 wrap, x1 wrap,
// x4 saturating 4-bit, undebounced velocity unit) driven from one vector table.

module tb_quad_decoder_param;
    logic clk = 1'b0, reset = 1'b1, clear = 1'b0;
    logic a = 1'b0, b = 1'b0, va = 1'b0, vb = 1'b0;
    always #10 clk = ~clk;

    logic [7:0] cnt0, cnt1, cnt3, vel0, vel1, vel2, vel3;
    logic [3:0] cnt2;
    logic cw0, ccw0, stp0, err0, vv0;
    logic cw1, ccw1, stp1, err1, vv1;
    logic cw2, ccw2, stp2, err2, vv2;
    logic cw3, ccw3, stp3, err3, vv3;

    quad_decoder_param #(.WIDTH(8), .DEBOUNCE(4), .MODE(0), .SATURATE(0), .WINDOW(100), .VWIDTH(8)) u0 (
        .clk(clk), .reset(reset), .A(a), .B(b), .clear(clear), .count(cnt0), .CW(cw0), .CWW(ccw0),
        .step(stp0), .err(err0), .velocity(vel0), .vel_valid(vv0));
    quad_decoder_param #(.WIDTH(8), .DEBOUNCE(4), .MODE(1), .SATURATE(0), .WINDOW(100), .VWIDTH(8)) u1 (
        .clk(clk), .reset(reset), .A(a), .B(b), .clear(clear), .count(cnt1), .CW(cw1), .CWW(ccw1),
        .step(stp1), .err(err1), .velocity(vel1), .vel_valid(vv1));
    quad_decoder_param #(.WIDTH(4), .DEBOUNCE(4), .MODE(0), .SATURATE(1), .WINDOW(100), .VWIDTH(8)) u2 (
        .clk(clk), .reset(reset), .A(a), .B(b), .clear(clear), .count(cnt2), .CW(cw2), .CWW(ccw2),
        .step(stp2), .err(err2), .velocity(vel2), .vel_valid(vv2));
    quad_decoder_param #(.WIDTH(8), .DEBOUNCE(0), .MODE(0), .SATURATE(0), .WINDOW(100), .VWIDTH(8)) u3 (
        .clk(clk), .reset(reset), .A(va), .B(vb), .clear(clear), .count(cnt3), .CW(cw3), .CWW(ccw3),
        .step(stp3), .err(err3), .velocity(vel3), .vel_valid(vv3));

    int checks = 0, failures = 0;
    int ns0 = 0, ns1 = 0, ns2 = 0;

    // Step pulses counted cycle by cycle, so a stretched pulse shows up as extra.
    always @(posedge clk) begin
        if (stp0) ns0 <= ns0 + 1;
        if (stp1) ns1 <= ns1 + 1;
        if (stp2) ns2 <= ns2 + 1;
    end

    typedef struct {
        logic a, b, g, clr;
        int   c0, c1, c2;
        logic cw, ccw, er;
        int   s0, s1, s2;
    } vec_t;
    vec_t tv[$];

    task automatic add(input logic a_, b_, g_, c_, input int c0, c1, c2,
                       input logic cw_, ccw_, er_, input int s0, s1, s2);
        vec_t v;
        v.a = a_; v.b = b_; v.g = g_; v.clr = c_;
        v.c0 = c0; v.c1 = c1; v.c2 = c2;
        v.cw = cw_; v.ccw = ccw_; v.er = er_;
        v.s0 = s0; v.s1 = s1; v.s2 = s2;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic [1:0] seq [4];
    int p = 0;

    task automatic vel_phase(input int dir, input int expv);
        int nwin = 0;
        int last = 0;
        for (int t = 0; t < 600; t++) begin
            if (t % 10 == 0) begin
                p = (p + dir) & 3;
                {va, vb} = seq[p];
            end
            @(negedge clk);
            if (vv3) begin
`ifdef QDEC_VELOCITY_EN
                if (nwin >= 1) begin
                    chk($sformatf("velocity dir%0d win%0d", dir, nwin), $signed(vel3), expv);
                    chk($sformatf("vel_valid spacing dir%0d win%0d", dir, nwin), t - last, 100);
                end
`endif
                last = t;
                nwin++;
            end
        end
`ifdef QDEC_VELOCITY_EN
        chk($sformatf("vel_valid window count dir%0d (>=5)", dir), int'(nwin >= 5), 1);
`else
        chk($sformatf("vel_valid pulses disabled dir%0d", dir), nwin, 0);
        chk($sformatf("velocity disabled dir%0d", dir), int'(vel3), expv * 0);
`endif
    endtask

    initial begin
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;

        // a b g clr | cnt x4 / x1 / sat4 | CW CWW err | cumulative step pulses
        add(1,0,0,0,   1,  0,  1, 1,0,0,  1,0, 1);
        add(1,1,0,0,   2,  0,  2, 1,0,0,  2,0, 2);
        add(0,1,0,0,   3,  0,  3, 1,0,0,  3,0, 3);
        add(0,0,0,0,   4,  1,  4, 1,0,0,  4,1, 4);
        add(1,0,0,0,   5,  1,  5, 1,0,0,  5,1, 5);
        add(1,1,0,0,   6,  1,  6, 1,0,0,  6,1, 6);
        add(0,1,0,0,   7,  1,  7, 1,0,0,  7,1, 7);
        add(0,0,0,0,   8,  2,  8, 1,0,0,  8,2, 8);
        add(1,0,1,0,   9,  2,  9, 1,0,0,  9,2, 9);
        add(1,1,1,0,  10,  2, 10, 1,0,0, 10,2,10);
        add(0,1,0,0,  11,  2, 11, 1,0,0, 11,2,11);
        add(0,0,0,0,  12,  3, 12, 1,0,0, 12,3,12);
        add(1,0,1,0,  13,  3, 13, 1,0,0, 13,3,13);
        add(1,1,1,0,  14,  3, 14, 1,0,0, 14,3,14);
        add(0,1,0,0,  15,  3, 15, 1,0,0, 15,3,15);
        add(0,0,0,0,  16,  4, 15, 1,0,0, 16,4,15);
        add(1,0,0,0,  17,  4, 15, 1,0,0, 17,4,15);
        add(1,1,0,0,  18,  4, 15, 1,0,0, 18,4,15);
        add(0,1,0,0,  19,  4, 15, 1,0,0, 19,4,15);
        add(0,0,0,0,  20,  5, 15, 1,0,0, 20,5,15);
        add(0,1,0,0,  19,  4, 14, 0,1,0, 21,6,16);
        add(0,1,0,1,   0,  0,  0, 0,1,0, 21,6,16);
        add(1,1,0,0, 255,  0,  0, 0,1,0, 22,6,16);
        add(1,0,0,0, 254,  0,  0, 0,1,0, 23,6,16);
        add(0,0,0,0, 253,  0,  0, 0,1,0, 24,6,16);
        add(0,1,0,0, 252,255,  0, 0,1,0, 25,7,16);
        add(1,1,0,0, 251,255,  0, 0,1,0, 26,7,16);
        add(1,0,0,0, 250,255,  0, 0,1,0, 27,7,16);
        add(0,0,0,0, 249,255,  0, 0,1,0, 28,7,16);
        add(0,1,0,0, 248,254,  0, 0,1,0, 29,8,16);
        add(1,1,0,0, 247,254,  0, 0,1,0, 30,8,16);
        add(1,0,0,0, 246,254,  0, 0,1,0, 31,8,16);
        add(0,0,0,0, 245,254,  0, 0,1,0, 32,8,16);
        add(0,1,0,0, 244,253,  0, 0,1,0, 33,9,16);
        add(1,0,0,0, 244,253,  0, 0,1,1, 33,9,16);
        add(1,0,0,1,   0,  0,  0, 0,1,0, 33,9,16);
        add(1,1,0,0,   1,  0,  1, 1,0,0, 34,9,17);

        repeat (3) @(negedge clk);
        chk("reset count", int'(cnt0), 0);
        chk("reset CW", int'(cw0), 0);
        chk("reset CWW", int'(ccw0), 0);
        chk("reset step", int'(stp0), 0);
        chk("reset err", int'(err0), 0);
        chk("reset velocity", int'(vel3), 0);
        chk("reset vel_valid", int'(vv3), 0);
        reset = 1'b0;

        // Each row holds one encoder state for 12 cycles; glitch rows drop A for one clock at cycle 8.
        for (int i = 0; i < tv.size(); i++) begin
            for (int c = 0; c < 12; c++) begin
                clear = tv[i].clr && (c == 0);
                a     = (tv[i].g && c == 8) ? 1'b0 : tv[i].a;
                b     = tv[i].b;
                @(negedge clk);
            end
            chk($sformatf("row%0d count x4", i), int'(cnt0), tv[i].c0);
            chk($sformatf("row%0d count x1", i), int'(cnt1), tv[i].c1);
            chk($sformatf("row%0d count sat4", i), int'(cnt2), tv[i].c2);
            chk($sformatf("row%0d CW", i), int'(cw0), int'(tv[i].cw));
            chk($sformatf("row%0d CWW", i), int'(ccw0), int'(tv[i].ccw));
            chk($sformatf("row%0d err", i), int'(err0), int'(tv[i].er));
            chk($sformatf("row%0d steps x4", i), ns0, tv[i].s0);
            chk($sformatf("row%0d steps x1", i), ns1, tv[i].s1);
            chk($sformatf("row%0d steps sat4", i), ns2, tv[i].s2);
        end

        // Reset while an 11->01 change is still inside the filters.
        a = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset count", int'(cnt0), 0);
        chk("midreset CW", int'(cw0), 0);
        chk("midreset CWW", int'(ccw0), 0);
        chk("midreset err", int'(err0), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("resume count x4", int'(cnt0), 255);
        chk("resume count x1", int'(cnt1), 255);
        chk("resume count sat4", int'(cnt2), 0);
        chk("resume CWW", int'(ccw0), 1);
        chk("resume CW", int'(cw0), 0);
        chk("resume steps x4", ns0, 35);
        chk("resume steps x1", ns1, 10);
        chk("resume steps sat4", ns2, 17);

        vel_phase(1, 10);
        vel_phase(-1, -10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
